// File: rtl/wb_ip_dispatch.sv
// Wishbone dispatcher: decodes the bridge address into one-hot slave selects, sequences one transfer at a time,
// muxes read data back, and flags decode errors. Optional slave-ack timeout is enabled by WB_DISPATCH_TIMEOUT_EN.
`timescale 1ns/1ps
module wb_ip_dispatch #(
  parameter int NUM_SLV  = 4,
  parameter int SEL_LSB  = 10,
  parameter int SEL_BITS = 3,
  parameter int TMO_CYC  = 255
) (
  input  logic                   WB_CLK,
  input  logic                   WB_RST_n,
  input  logic [16:0]            WBs_ADR,
  input  logic                   WBs_CYC,
  input  logic                   WBs_STB,
  input  logic                   WBs_WE,
  input  logic [3:0]             WBs_BYTE_STB,
  input  logic [31:0]            WBs_WR_DAT,
  output logic [31:0]            WBs_RD_DAT,
  output logic                   WBs_ACK,
  output logic [NUM_SLV-1:0]     slv_cyc_o,
  input  logic [NUM_SLV-1:0]     slv_ack_i,
  input  logic [32*NUM_SLV-1:0]  slv_rd_dat_i,
  output logic                   err_flag_o,
  output logic [16:0]            err_addr_o,
  input  logic                   err_clr_i
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                state, state_nxt;
  logic                  skip_q;
  logic [SEL_BITS-1:0]   idx;
  logic                  mapped;
  logic                  sel_ack;
  logic [31:0]           sel_dat;
  logic [NUM_SLV-1:0]    cyc_nxt;
  logic [31:0]           rd_nxt;
  logic                  err_set;
  logic [16:0]           err_adr;
  logic                  timeout;

  // Write-side bus signals go straight from the bridge to the slaves; the dispatcher never looks at them.
  logic unused_bus;
  assign unused_bus = &{1'b0, WBs_WE, WBs_BYTE_STB, WBs_WR_DAT};

  assign idx     = WBs_ADR[SEL_LSB +: SEL_BITS];
  assign mapped  = int'(idx) < NUM_SLV;
  assign WBs_ACK = (state == DONE);

`ifdef WB_DISPATCH_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'(TMO_CYC);
  logic [7:0]  cnt_q;
  logic [16:0] adr_q;

  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      cnt_q <= '0;
      adr_q <= '0;
    end else if (state == IDLE) begin
      cnt_q <= '0;
      adr_q <= WBs_ADR;
    end else if (state == ACTIVE && cnt_q != 8'hFF) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign timeout = (cnt_q == TMO);
`else
  assign timeout = 1'b0;
`endif

  // slv_cyc_o is one-hot, so masking with it selects the active slave without an index decode.
  always_comb begin
    sel_ack = |(slv_ack_i & slv_cyc_o);
    sel_dat = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (slv_cyc_o[k]) sel_dat = slv_rd_dat_i[32*k +: 32];
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt = state;
    cyc_nxt   = slv_cyc_o;
    rd_nxt    = WBs_RD_DAT;
    err_set   = 1'b0;
    err_adr   = WBs_ADR;
    unique case (state)
      IDLE: begin
        if (WBs_CYC && WBs_STB && !skip_q) begin
          if (mapped) begin
            for (int k = 0; k < NUM_SLV; k++) cyc_nxt[k] = (int'(idx) == k);
            state_nxt = ACTIVE;
          end else begin
            rd_nxt    = 32'hBAD0_0000 | {15'b0, WBs_ADR};
            err_set   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      ACTIVE: begin
        if (!WBs_CYC) begin
          cyc_nxt   = '0;
          state_nxt = IDLE;
        end else if (sel_ack) begin
          rd_nxt    = sel_dat;
          cyc_nxt   = '0;
          state_nxt = DONE;
        end else if (timeout) begin
          rd_nxt    = 32'hDEAD_DEAD;
          cyc_nxt   = '0;
          err_set   = 1'b1;
`ifdef WB_DISPATCH_TIMEOUT_EN
          err_adr   = adr_q;
`endif
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments with an asynchronous active-low reset.
  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      slv_cyc_o  <= '0;
      WBs_RD_DAT <= '0;
      skip_q     <= 1'b0;
      err_flag_o <= 1'b0;
      err_addr_o <= '0;
    end else begin
      slv_cyc_o  <= cyc_nxt;
      WBs_RD_DAT <= rd_nxt;
      // The bridge may still show STB for one cycle after ACK; that cycle must not start a new transfer.
      skip_q     <= (state == DONE);
      if (err_set) begin
        err_flag_o <= 1'b1;
        if (!err_flag_o || err_clr_i) err_addr_o <= err_adr;
      end else if (err_clr_i) begin
        err_flag_o <= 1'b0;
        err_addr_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_ip_dispatch.sv
// Self-checking bench for wb_ip_dispatch: directed spec scenarios plus randomized transfers against a
// transaction-level model (expected select, latency, read data and sticky error state).
`timescale 1ns/1ps
module tb_wb_ip_dispatch;
  localparam int NUM_SLV  = 4;
  localparam int SEL_LSB  = 10;
  localparam int SEL_BITS = 3;
`ifdef WB_DISPATCH_TIMEOUT_EN
  localparam int TMO_CYC  = 8;
`else
  localparam int TMO_CYC  = 255;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [16:0]           adr;
  logic                  cyc, stb, we;
  logic [3:0]            byte_stb;
  logic [31:0]           wr_dat;
  logic [31:0]           rd_dat;
  logic                  ack;
  logic [NUM_SLV-1:0]    slv_cyc;
  logic [NUM_SLV-1:0]    slv_ack;
  logic [32*NUM_SLV-1:0] slv_rd_dat;
  logic                  err_flag;
  logic [16:0]           err_addr;
  logic                  err_clr;

  wb_ip_dispatch #(.NUM_SLV(NUM_SLV), .SEL_LSB(SEL_LSB), .SEL_BITS(SEL_BITS), .TMO_CYC(TMO_CYC)) dut (
    .WB_CLK(clk), .WB_RST_n(rst_n), .WBs_ADR(adr), .WBs_CYC(cyc), .WBs_STB(stb), .WBs_WE(we),
    .WBs_BYTE_STB(byte_stb), .WBs_WR_DAT(wr_dat), .WBs_RD_DAT(rd_dat), .WBs_ACK(ack),
    .slv_cyc_o(slv_cyc), .slv_ack_i(slv_ack), .slv_rd_dat_i(slv_rd_dat),
    .err_flag_o(err_flag), .err_addr_o(err_addr), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        m_flag;
  logic [16:0] m_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_err(input logic [16:0] a, input logic clr);
    if (!m_flag || clr) m_addr = a;
    m_flag = 1'b1;
  endtask

  task automatic model_clr();
    m_flag = 1'b0;
    m_addr = '0;
  endtask

  task automatic check_err(input string tag);
    check({tag, "_flag"}, 64'(err_flag), 64'(m_flag));
    check({tag, "_addr"}, 64'(err_addr), 64'(m_addr));
  endtask

  // Present a request at a negedge; sdat is what the addressed slave returns.
  task automatic drive_req(input logic [16:0] a, input logic w, input logic [31:0] sdat, input logic clr);
    int idx;
    idx = int'(a[SEL_LSB +: SEL_BITS]);
    adr = a; we = w; cyc = 1'b1; stb = 1'b1; err_clr = clr;
    byte_stb = 4'($urandom); wr_dat = $urandom;
    for (int k = 0; k < NUM_SLV; k++) slv_rd_dat[32*k +: 32] = $urandom;
    if (idx < NUM_SLV) slv_rd_dat[32*idx +: 32] = sdat;
  endtask

  // One complete transfer. d = edges after the select rises at which the slave acks; d = 0 means never.
  // The bridge keeps STB up for two cycles after ACK to prove the dispatcher does not restart.
  task automatic xfer(input logic [16:0] a, input logic w, input int d, input logic [31:0] sdat,
                      input logic clr);
    int                 idx;
    int                 wait_cyc;
    logic [NUM_SLV-1:0] oh;
    logic [31:0]        exp_dat;
    idx = int'(a[SEL_LSB +: SEL_BITS]);
    drive_req(a, w, sdat, clr);
    @(negedge clk);
    err_clr = 1'b0;
    if (idx >= NUM_SLV) begin
      model_err(a, clr);
      exp_dat = 32'hBAD0_0000 | {15'b0, a};
    end else begin
      if (clr) model_clr();
      oh = '0;
      oh[idx] = 1'b1;
      wait_cyc = (d == 0) ? TMO_CYC + 1 : d;
      for (int j = 1; j <= wait_cyc; j++) begin
        check("cyc_sel", 64'(slv_cyc), 64'(oh));
        check("ack_early", 64'(ack), 64'd0);
        slv_ack = NUM_SLV'($urandom) & ~oh;
        if (j == d) slv_ack = slv_ack | oh;
        @(negedge clk);
      end
      slv_ack = '0;
      if (d == 0) begin
        model_err(a, 1'b0);
        exp_dat = 32'hDEAD_DEAD;
      end else begin
        exp_dat = sdat;
      end
    end
    check("ack", 64'(ack), 64'd1);
    check("rd_dat", 64'(rd_dat), 64'(exp_dat));
    check("cyc_off", 64'(slv_cyc), 64'd0);
    check_err("err");
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      check("ack_single", 64'(ack), 64'd0);
      check("no_restart", 64'(slv_cyc), 64'd0);
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    model_clr();
    check_err("clr");
  endtask

  // Start a mapped access with no slave ack, then end it by dropping CYC or by pulsing reset.
  task automatic interrupt(input logic [16:0] a, input int k, input logic use_rst);
    drive_req(a, 1'b0, 32'h0, 1'b0);
    slv_ack = '0;
    for (int j = 0; j < k; j++) @(negedge clk);
    if (use_rst) begin
      rst_n = 1'b0;
      #1;
      model_clr();
      check("rst_cyc", 64'(slv_cyc), 64'd0);
      check("rst_ack", 64'(ack), 64'd0);
      check("rst_rd", 64'(rd_dat), 64'd0);
      check_err("rst_err");
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 1'b0; stb = 1'b0;
    end else begin
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      check("abort_cyc", 64'(slv_cyc), 64'd0);
      check("abort_ack", 64'(ack), 64'd0);
      check_err("abort_err");
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("idle_ack", 64'(ack), 64'd0);
      check("idle_cyc", 64'(slv_cyc), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] ra;
    rst_n = 1'b0; adr = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0; byte_stb = '0; wr_dat = '0;
    slv_ack = '0; slv_rd_dat = '0; err_clr = 1'b0;
    model_clr();
    repeat (3) @(negedge clk);
    check("reset_ack", 64'(ack), 64'd0);
    check("reset_rd", 64'(rd_dat), 64'd0);
    check("reset_cyc", 64'(slv_cyc), 64'd0);
    check_err("reset_err");
    rst_n = 1'b1;
    @(negedge clk);

    xfer(17'h00404, 1'b1, 2, $urandom, 1'b0);
    xfer(17'h00C00, 1'b0, 1, 32'h1234_5678, 1'b0);
    xfer(17'h01400, 1'b0, 1, 32'h0, 1'b0);
    check("first_err_addr", 64'(err_addr), 64'h01400);
    xfer(17'h01800, 1'b0, 1, 32'h0, 1'b0);
    clear_err();
`ifdef WB_DISPATCH_TIMEOUT_EN
    xfer(17'h00010, 1'b0, 0, 32'h0, 1'b0);
    check("tmo_addr", 64'(err_addr), 64'h00010);
    xfer(17'h01C00, 1'b1, 1, 32'h0, 1'b0);
    clear_err();
`endif
    xfer(17'h01000, 1'b0, 1, 32'h0, 1'b0);
    xfer(17'h11404, 1'b0, 1, 32'h0, 1'b1);
    clear_err();

    interrupt(17'h00800, 3, 1'b0);
    xfer(17'h00800, 1'b0, 3, 32'hCAFE_0002, 1'b0);
    xfer(17'h01400, 1'b0, 1, 32'h0, 1'b0);
    interrupt(17'h00400, 2, 1'b1);
    xfer(17'h00400, 1'b1, 2, 32'hCAFE_0001, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = {4'($urandom), 3'($urandom_range(0, 7)), 10'($urandom)};
      xfer(ra, 1'($urandom), $urandom_range(1, 6), $urandom, ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
